tqvp_sprite_engine: RTL and testbench

Parametrised TinyQV sprite peripheral that composites up to 8 scaled 8×8 1bpp sprites over a background colour for a 640×480 raster. It takes the raster position from the external video timing block and drives registered RGB222 plus delayed syncs toward the output PMOD. It adds three things over the single-table sprite peripheral:
- a committed double-buffered object table,
- a shared bitmap pool,
- per-sprite collision detection, with a maskable interrupt.

---
 rtl/tqvp_sprite_engine.sv | 190 +++++++++++++++++++
 tb/tb_tqvp_sprite_engine.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_sprite_engine.sv
// TinyQV sprite engine: 8x8 1bpp scaled sprites, committed object table,
// shared bitmap pool. Collision logic under `define SPRITE_COLLISION_EN.
module tqvp_sprite_engine #(
  parameter int NUM_SPRITES = 4,
  parameter int NUM_BITMAPS = 2,
  parameter int SCALE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        visible,
  input  logic        hsync,
  input  logic        vsync,
  output logic [5:0]  rgb,
  output logic        hsync_q,
  output logic        vsync_q
);

  localparam int SH = (SCALE >= 8) ? 3 : (SCALE >= 4) ? 2 : (SCALE >= 2) ? 1 : 0;
  localparam logic [10:0] SPAN = 11'(8 * SCALE);
  localparam logic [2:0] NBMP = 3'(NUM_BITMAPS);

  logic [31:0] stg [8];
  logic [31:0] act [8];
  logic [7:0]  bmp [32];
  logic        commit, disp_en;
  logic [5:0]  bg;
  logic [1:0]  irq_st, irq_en;
  logic [7:0]  coll;
  logic [7:0]  fcnt;
  logic        vsync_d;
  logic        vs_edge;
  logic        coll_evt;

  logic [3:0]  lane;
  logic [63:0] we;
  logic [7:0]  wd [64];
  logic [6:0]  wa, ra;
  logic [7:0]  rb [64];

  logic [7:0]  hit;
  logic [5:0]  col [8];
  logic [5:0]  pix_col;

  assign data_ready = 1'b1;
  assign vs_edge = vsync & ~vsync_d;
  assign user_interrupt = |(irq_st & irq_en);

  always_comb begin
    case (data_write_n)
      2'b00:   lane = 4'b0001;
      2'b01:   lane = 4'b0011;
      2'b10:   lane = 4'b1111;
      default: lane = 4'b0000;
    endcase
  end

  // Fan the bus lanes out to per-byte-address strobes.
  always_comb begin
    we = '0;
    wa = '0;
    for (int a = 0; a < 64; a++) wd[a] = '0;
    for (int k = 0; k < 4; k++) begin
      wa = {1'b0, address} + 7'(k);
      if (lane[k] && !wa[6]) begin
        we[wa[5:0]] = 1'b1;
        wd[wa[5:0]] = data_in[8*k +: 8];
      end
    end
  end

  always_comb begin
    ra = '0;
    for (int a = 0; a < 64; a++) rb[a] = '0;
    for (int n = 0; n < NUM_SPRITES; n++)
      for (int k = 0; k < 4; k++) rb[4*n+k] = stg[n][8*k +: 8];
    for (int i = 0; i < NUM_BITMAPS * 8; i++) rb[32+i] = bmp[i];
    rb[56] = {6'b0, disp_en, commit};
    rb[57] = {2'b0, bg};
    rb[58] = {6'b0, irq_st};
    rb[59] = {6'b0, irq_en};
    rb[60] = coll;
    rb[61] = fcnt;
    data_out = '0;
    for (int k = 0; k < 4; k++) begin
      ra = {1'b0, address} + 7'(k);
      if (data_read_n != 2'b11 && !ra[6])
        data_out[8*k +: 8] = rb[ra[5:0]];
    end
  end

  for (genvar n = 0; n < 8; n++) begin : g_spr
    if (n < NUM_SPRITES) begin : g_on
      logic [10:0] dx, dy;
      logic [2:0]  bsel, ry;
      logic [7:0]  rowb;
      assign dx = {1'b0, pix_x} - {1'b0, act[n][7:0], 2'b00};
      assign dy = {1'b0, pix_y} - {1'b0, act[n][15:8], 2'b00};
      // Bit 7 is leftmost, so unflipped column c selects bit ~c.
      assign bsel = dx[SH +: 3] ^ {3{~act[n][31]}};
      assign ry = dy[SH +: 3];
      assign rowb = ({1'b0, act[n][25:24]} < NBMP) ?
                    bmp[{act[n][25:24], ry}] : 8'h00;
      assign hit[n] = act[n][23] & (dx < SPAN) & (dy < SPAN) & rowb[bsel];
      assign col[n] = act[n][21:16];
    end else begin : g_off
      assign hit[n] = 1'b0;
      assign col[n] = '0;
    end
  end

  always_comb begin
    pix_col = bg;
    for (int n = 7; n >= 0; n--)
      if (hit[n]) pix_col = col[n];
  end

`ifdef SPRITE_COLLISION_EN
  logic multi;
  assign multi = |(hit & (hit - 8'd1));
  assign coll_evt = visible & disp_en & multi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll <= '0;
    end else begin
      coll <= (coll & ~(we[60] ? wd[60] : 8'h00)) | (coll_evt ? hit : 8'h00);
    end
  end
`else
  assign coll_evt = 1'b0;
  assign coll = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        stg[i] <= '0;
        act[i] <= '0;
      end
      for (int i = 0; i < 32; i++) bmp[i] <= '0;
      commit  <= 1'b0;
      disp_en <= 1'b0;
      bg      <= '0;
      irq_st  <= '0;
      irq_en  <= '0;
      fcnt    <= '0;
      // Primed high so a vsync held through reset is not seen as an edge.
      vsync_d <= 1'b1;
      rgb     <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_SPRITES; n++) begin
        if (we[4*n])   stg[n][7:0]   <= wd[4*n];
        if (we[4*n+1]) stg[n][15:8]  <= wd[4*n+1];
        if (we[4*n+2]) stg[n][23:16] <= wd[4*n+2] & 8'hBF;
        if (we[4*n+3]) stg[n][31:24] <= wd[4*n+3] & 8'h83;
      end
      for (int i = 0; i < NUM_BITMAPS * 8; i++)
        if (we[32+i]) bmp[i] <= wd[32+i];
      if (vs_edge && commit) begin
        for (int i = 0; i < 8; i++) act[i] <= stg[i];
        commit <= 1'b0;
      end
      if (we[56]) begin
        disp_en <= wd[56][1];
        if (wd[56][0]) commit <= 1'b1;
      end
      if (we[57]) bg <= wd[57][5:0];
      if (we[59]) irq_en <= wd[59][1:0];
      irq_st  <= (irq_st & ~(we[58] ? wd[58][1:0] : 2'b00)) |
                 {coll_evt, vs_edge};
      fcnt    <= fcnt + {7'b0, vs_edge};
      vsync_d <= vsync;
      rgb     <= (visible && disp_en) ? pix_col : 6'h00;
      hsync_q <= hsync;
      vsync_q <= vsync;
    end
  end

endmodule

// File: tb/tb_tqvp_sprite_engine.sv
// Scoreboard bench for tqvp_sprite_engine: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_tqvp_sprite_engine;

`ifdef SPRITE_COLLISION_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  localparam int K_RGB = 0;
  localparam int K_RD8 = 1;
  localparam int K_RD32 = 2;
  localparam int K_IRQ = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;
  logic [9:0]  pix_x, pix_y;
  logic        visible, hsync, vsync;
  logic [5:0]  rgb;
  logic        hsync_q, vsync_q;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   fc = 0;

  always #5 clk = ~clk;

  tqvp_sprite_engine #(
    .NUM_SPRITES(4),
    .NUM_BITMAPS(2),
    .SCALE(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .address(address),
    .data_in(data_in),
    .data_write_n(data_write_n),
    .data_read_n(data_read_n),
    .data_out(data_out),
    .data_ready(data_ready),
    .user_interrupt(user_interrupt),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .visible(visible),
    .hsync(hsync),
    .vsync(vsync),
    .rgb(rgb),
    .hsync_q(hsync_q),
    .vsync_q(vsync_q)
  );

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] got;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        K_RGB:   got = {26'b0, rgb};
        K_RD8:   got = {24'b0, data_out[7:0]};
        K_RD32:  got = data_out;
        default: got = {31'b0, user_interrupt};
      endcase
      n_vec++;
      if (got !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %0h, expected %0h", e.name, got, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(string nm, int kind, logic [31:0] e);
    q.push_back('{nm, kind, e});
  endtask

  task automatic wr(logic [5:0] a, logic [31:0] d, logic [1:0] mode);
    address = a;
    data_in = d;
    data_write_n = mode;
    step();
    data_write_n = 2'b11;
  endtask

  task automatic rd(logic [5:0] a, int kind, logic [31:0] e, string nm);
    address = a;
    push(nm, kind, e);
    step();
  endtask

  task automatic pix(int x, int y, logic [5:0] e, string nm);
    pix_x = 10'(x);
    pix_y = 10'(y);
    step();
    push(nm, K_RGB, {26'b0, e});
    step();
  endtask

  task automatic irq(logic e, string nm);
    push(nm, K_IRQ, {31'b0, e});
    step();
  endtask

  task automatic vs();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
    fc++;
  endtask

  initial begin
    rst_n = 1'b0;
    address = '0;
    data_in = '0;
    data_write_n = 2'b11;
    data_read_n = 2'b10;
    pix_x = '0;
    pix_y = '0;
    visible = 1'b0;
    hsync = 1'b0;
    vsync = 1'b0;
    step();
    step();
    push("reset_rgb", K_RGB, 32'h0);
    push("reset_irq", K_IRQ, 32'h0);
    rd(6'h38, K_RD8, 32'h0, "reset_ctrl");
    rst_n = 1'b1;
    step();

    wr(6'h39, 32'h01, 2'b00);
    wr(6'h20, 32'h80, 2'b00);
    wr(6'h00, 32'h00B0050A, 2'b10);
    wr(6'h38, 32'h03, 2'b00);
    vs();
    visible = 1'b1;
    pix(40, 20, 6'h30, "hit_tl");
    pix(43, 23, 6'h30, "hit_br");
    pix(44, 20, 6'h01, "bg_right");
    pix(40, 24, 6'h01, "bg_row1");
    rd(6'h38, K_RD8, 32'h02, "ctrl_after_commit");
    rd(6'h3A, K_RD8, 32'h01, "frame_irq");
    rd(6'h3D, K_RD8, 32'h01, "frame_cnt1");

    wr(6'h03, 32'h80, 2'b00);
    wr(6'h38, 32'h03, 2'b00);
    vs();
    pix(68, 20, 6'h30, "flip_68");
    pix(71, 23, 6'h30, "flip_71");
    pix(40, 20, 6'h01, "flip_40");

    wr(6'h00, 32'h14, 2'b00);
    vs();
    vs();
    pix(68, 20, 6'h30, "stage_unchanged");
    rd(6'h00, K_RD8, 32'h14, "stage_x");
    rd(6'h00, K_RD32, 32'h80B00514, "stage_word");
    wr(6'h38, 32'h03, 2'b00);
    vs();
    pix(108, 20, 6'h30, "moved_new");
    pix(68, 20, 6'h01, "moved_old");
    rd(6'h38, K_RD8, 32'h02, "commit_cleared");

    wr(6'h08, 32'h808C0514, 2'b10);
    wr(6'h3B, 32'h02, 2'b00);
    wr(6'h38, 32'h03, 2'b00);
    vs();
    pix(108, 20, 6'h30, "coll_colour");
    irq(COLL, "coll_irq");
    rd(6'h3C, K_RD8, COLL ? 32'h05 : 32'h0, "coll_flags");
    rd(6'h3A, K_RD8, COLL ? 32'h03 : 32'h01, "coll_status");
    wr(6'h3A, 32'h0202, 2'b01);
    wr(6'h3C, 32'h05, 2'b00);
    rd(6'h3C, K_RD8, COLL ? 32'h05 : 32'h0, "coll_reset_flags");
    rd(6'h3A, K_RD8, COLL ? 32'h03 : 32'h01, "coll_reset_status");
    irq(COLL, "coll_reset_irq");

    visible = 1'b0;
    pix(108, 20, 6'h00, "blank_rgb");
    wr(6'h3C, 32'h05, 2'b00);
    wr(6'h3A, 32'h02, 2'b00);
    rd(6'h3C, K_RD8, 32'h0, "blank_flags");
    rd(6'h3A, K_RD8, 32'h01, "blank_status");
    irq(1'b0, "blank_irq");

    wr(6'h20, 32'h44332211, 2'b10);
    rd(6'h20, K_RD8, 32'h11, "word_b0");
    rd(6'h21, K_RD8, 32'h22, "word_b1");
    rd(6'h22, K_RD8, 32'h33, "word_b2");
    rd(6'h23, K_RD8, 32'h44, "word_b3");
    rd(6'h20, K_RD32, 32'h44332211, "word_rd");
    wr(6'h3E, 32'hFFFF, 2'b01);
    rd(6'h3E, K_RD8, 32'h0, "half_3e");
    rd(6'h3D, K_RD8, 32'(fc), "frame_cnt_pre");

    while (fc < 256) vs();
    rd(6'h3D, K_RD8, 32'h0, "frame_wrap");

    wr(6'h3B, 32'h03, 2'b00);
    visible = 1'b1;
    pix(300, 300, 6'h01, "pre_reset_rgb");
    irq(1'b1, "pre_reset_irq");
    vsync = 1'b1;
    rst_n = 1'b0;
    address = 6'h38;
    push("async_rgb", K_RGB, 32'h0);
    push("async_irq", K_IRQ, 32'h0);
    push("async_ctrl", K_RD8, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    rd(6'h3D, K_RD8, 32'h0, "vsync_held");
    vsync = 1'b0;

    step();
    step();
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
